// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared CPU definitions. Holds the SRAM word-address width
//               default and the encodings used by the SRAM arbiter:
//                 arb_state_e - arbiter FSM state (idle / busy for IF / MEM)
//                 arb_owner_e - which requester currently drives the SRAM
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int c_SRAM_AW_DEFAULT = 20;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IF  = 2'd1,
        S_BUSY_MEM = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } arb_owner_e;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/sram_port_mux.sv
`default_nettype none
// ============================================================================
// Module      : sram_port_mux
// Description : Combinational SRAM port steering. Drives the SRAM address,
//               write data and active-low enables from whichever requester
//               owns the bus this cycle; parks the bus at idle values when
//               nobody owns it.
// Ports       : i_owner      - current bus owner (none / IF / MEM)
//               i_busy       - second (BUSY) cycle of the access
//               i_write      - owner access is a write (MEM only)
//               i_if_addr    - fetch byte address
//               i_mem_addr   - MEM byte address
//               i_mem_wdata  - MEM write data
//               i_mem_be_n   - MEM byte enables, active low
//               o_sram_*     - SRAM pins
// Revision    : 1.0 - initial release
// ============================================================================
module sram_port_mux
    import cpu_defs::*;
#(
    parameter int SRAM_AW = c_SRAM_AW_DEFAULT
) (
    input  arb_owner_e           i_owner,
    input  logic                 i_busy,
    input  logic                 i_write,
    input  logic [31:0]          i_if_addr,
    input  logic [31:0]          i_mem_addr,
    input  logic [31:0]          i_mem_wdata,
    input  logic [3:0]           i_mem_be_n,
    output logic [SRAM_AW-1:0]   o_sram_addr,
    output logic [31:0]          o_sram_wdata,
    output logic                 o_sram_wdata_oe,
    output logic                 o_sram_ce_n,
    output logic                 o_sram_oe_n,
    output logic                 o_sram_we_n,
    output logic [3:0]           o_sram_be_n
);

    // Byte-lane and high address bits are not part of the SRAM word address.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{i_if_addr[31:SRAM_AW+2], i_if_addr[1:0],
                                  i_mem_addr[31:SRAM_AW+2], i_mem_addr[1:0]};

    always_comb begin
        o_sram_addr     = '0;
        o_sram_wdata    = '0;
        o_sram_wdata_oe = 1'b0;
        o_sram_ce_n     = 1'b1;
        o_sram_oe_n     = 1'b1;
        o_sram_we_n     = 1'b1;
        o_sram_be_n     = 4'hF;
        case (i_owner)
            OWN_IF: begin
                o_sram_ce_n = 1'b0;
                o_sram_oe_n = 1'b0;
                o_sram_be_n = 4'h0;
                o_sram_addr = i_if_addr[SRAM_AW+1:2];
            end
            OWN_MEM: begin
                o_sram_ce_n     = 1'b0;
                o_sram_addr     = i_mem_addr[SRAM_AW+1:2];
                o_sram_be_n     = i_mem_be_n;
                o_sram_oe_n     = i_write;
                o_sram_wdata_oe = i_write;
                o_sram_wdata    = i_write ? i_mem_wdata : '0;
                // Write strobe only in the second cycle so address and data
                // are settled for a full cycle before WE falls.
                o_sram_we_n     = ~(i_write & i_busy);
            end
            default: ;
        endcase
    end

endmodule : sram_port_mux
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-requester arbiter for a single asynchronous SRAM shared by
//               instruction fetch (IF) and the MEM stage. MEM has fixed
//               priority. Every access takes two cycles: a grant cycle in
//               IDLE followed by one BUSY cycle in which read data is
//               returned and write strobe is asserted.
// Ports       : clk, rst                    - clock, sync active-high reset
//               if_req/if_addr              - fetch request / byte address
//               if_rdata/if_stall           - fetch read data / stall
//               mem_req/mem_we/mem_addr     - MEM request, direction, address
//               mem_wdata/mem_be_n          - MEM write data, byte enables
//               mem_rdata/mem_stall         - MEM read data / stall
//               sram_*                      - SRAM pins (enables active low)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import cpu_defs::*;
#(
    parameter int SRAM_AW = c_SRAM_AW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [31:0]          if_addr,
    output logic [31:0]          if_rdata,
    output logic                 if_stall,
    input  logic                 mem_req,
    input  logic                 mem_we,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_be_n,
    output logic [31:0]          mem_rdata,
    output logic                 mem_stall,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [31:0]          sram_wdata,
    output logic                 sram_wdata_oe,
    input  logic [31:0]          sram_rdata,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [3:0]           sram_be_n
);

    arb_state_e r_state;
    logic       r_mem_write;   // direction of the MEM access in flight

    arb_owner_e w_owner;
    logic       w_busy;
    logic       w_write;

    // Bus ownership: decided from live requests in IDLE (grant cycle), held
    // by the FSM state during the BUSY cycle. Reset parks the bus.
    always_comb begin
        w_owner = OWN_NONE;
        w_busy  = 1'b0;
        w_write = 1'b0;
        if (!rst) begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        w_owner = OWN_MEM;
                        w_write = mem_we;
                    end else if (if_req) begin
                        w_owner = OWN_IF;
                    end
                end
                S_BUSY_IF: begin
                    w_owner = OWN_IF;
                    w_busy  = 1'b1;
                end
                S_BUSY_MEM: begin
                    w_owner = OWN_MEM;
                    w_busy  = 1'b1;
                    w_write = r_mem_write;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        r_state     <= S_BUSY_MEM;
                        r_mem_write <= mem_we;
                    end else if (if_req) begin
                        r_state <= S_BUSY_IF;
                    end
                end
                S_BUSY_IF:  r_state <= S_IDLE;
                S_BUSY_MEM: r_state <= S_IDLE;
                default:    r_state <= S_IDLE;
            endcase
        end
    end

    // A requester is released only in its own BUSY cycle; in every other
    // cycle an active request is held off (grant cycle or losing side).
    assign if_stall  = ~rst & if_req  & (r_state != S_BUSY_IF);
    assign mem_stall = ~rst & mem_req & (r_state != S_BUSY_MEM);

    assign if_rdata  = (!rst && r_state == S_BUSY_IF) ? sram_rdata : 32'h0;
    assign mem_rdata = (!rst && r_state == S_BUSY_MEM && !r_mem_write) ?
                       sram_rdata : 32'h0;

    sram_port_mux #(
        .SRAM_AW (SRAM_AW)
    ) u_port_mux (
        .i_owner         (w_owner),
        .i_busy          (w_busy),
        .i_write         (w_write),
        .i_if_addr       (if_addr),
        .i_mem_addr      (mem_addr),
        .i_mem_wdata     (mem_wdata),
        .i_mem_be_n      (mem_be_n),
        .o_sram_addr     (sram_addr),
        .o_sram_wdata    (sram_wdata),
        .o_sram_wdata_oe (sram_wdata_oe),
        .o_sram_ce_n     (sram_ce_n),
        .o_sram_oe_n     (sram_oe_n),
        .o_sram_we_n     (sram_we_n),
        .o_sram_be_n     (sram_be_n)
    );

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter. A small SRAM model
//               answers reads and absorbs writes; expected completions are
//               queued when requests are issued and popped by a monitor
//               whenever a requester is released (req=1, stall=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be_n;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_wdata_oe;
    logic [31:0] sram_rdata;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  be_n;
    } exp_t;

    exp_t        exp_if[$];
    exp_t        exp_mem[$];
    logic [31:0] model_mem [0:511];   // reference contents (transaction order)
    logic [31:0] sram_mem  [0:511];   // bench SRAM device contents

    sram_arbiter #(.SRAM_AW(20)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_rdata      (if_rdata),
        .if_stall      (if_stall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be_n      (mem_be_n),
        .mem_rdata     (mem_rdata),
        .mem_stall     (mem_stall),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_wdata_oe (sram_wdata_oe),
        .sram_rdata    (sram_rdata),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_be_n     (sram_be_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom(input int w);
        return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // SRAM device: asynchronous read, write on WE low sampled at each edge.
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[8:0]] : 32'h0;

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i]  = rom(i);
            model_mem[i] = rom(i);
        end
        sram_mem[4]  = 32'h24020001;
        model_mem[4] = 32'h24020001;
        forever begin
            @(posedge clk);
            if (!sram_ce_n && !sram_we_n && sram_wdata_oe) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_be_n[b]) sram_mem[sram_addr[8:0]][8*b +: 8] = sram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input int w, input logic [31:0] d);
        exp_if.push_back('{1'b0, 20'(w), d, 4'h0});
    endtask

    task automatic push_mem_write(input int w, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (!be[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
        exp_mem.push_back('{1'b1, 20'(w), d, be});
    endtask

    task automatic push_mem_read(input int w, input logic [3:0] be);
        exp_mem.push_back('{1'b0, 20'(w), model_mem[w], be});
    endtask

    // Monitor: a requester released while requesting is a completed access.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (if_req && !if_stall) begin
                if (exp_if.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL if_unexpected_completion: got addr %h expected none", sram_addr);
                end else begin
                    e = exp_if.pop_front();
                    chk("mon_if_addr",  32'(sram_addr), 32'(e.addr));
                    chk("mon_if_rdata", if_rdata, e.data);
                    chk("mon_if_be_n",  32'(sram_be_n), 32'h0);
                    chk("mon_if_oe_n",  32'(sram_oe_n), 32'h0);
                end
            end
            if (mem_req && !mem_stall) begin
                if (exp_mem.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL mem_unexpected_completion: got addr %h expected none", sram_addr);
                end else begin
                    e = exp_mem.pop_front();
                    chk("mon_mem_addr", 32'(sram_addr), 32'(e.addr));
                    chk("mon_mem_be_n", 32'(sram_be_n), 32'(e.be_n));
                    if (e.we) begin
                        chk("mon_mem_we_n",     32'(sram_we_n), 32'h0);
                        chk("mon_mem_wdata",    sram_wdata, e.data);
                        chk("mon_mem_wdata_oe", 32'(sram_wdata_oe), 32'h1);
                    end else begin
                        chk("mon_mem_rdata", mem_rdata, e.data);
                        chk("mon_mem_oe_n",  32'(sram_oe_n), 32'h0);
                    end
                end
            end
            if (!if_req) chk("mon_if_idle_stall", 32'(if_stall), 32'h0);
            if (!mem_req) chk("mon_mem_idle_stall", 32'(mem_stall), 32'h0);
        end
    end

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_ce_n"},     32'(sram_ce_n), 32'h1);
        chk({tag, "_oe_n"},     32'(sram_oe_n), 32'h1);
        chk({tag, "_we_n"},     32'(sram_we_n), 32'h1);
        chk({tag, "_be_n"},     32'(sram_be_n), 32'hF);
        chk({tag, "_wdata_oe"}, 32'(sram_wdata_oe), 32'h0);
        chk({tag, "_addr"},     32'(sram_addr), 32'h0);
        chk({tag, "_wdata"},    sram_wdata, 32'h0);
    endtask

    task automatic directed_fetch();
        if_addr = 32'h80000010;
        if_req  = 1'b1;
        push_if(4, 32'h24020001);
        @(negedge clk);
        chk("fetch_c1_addr",  32'(sram_addr), 32'h00004);
        chk("fetch_c1_stall", 32'(if_stall), 32'h1);
        chk("fetch_c1_rdata", if_rdata, 32'h0);
        chk("fetch_c1_ce_n",  32'(sram_ce_n), 32'h0);
        step();
        @(negedge clk);
        chk("fetch_c2_addr",  32'(sram_addr), 32'h00004);
        chk("fetch_c2_stall", 32'(if_stall), 32'h0);
        chk("fetch_c2_rdata", if_rdata, 32'h24020001);
        step();
        if_req = 1'b0;
        @(negedge clk);
        chk_bus_idle("fetch_after");
        step();
    endtask

    task automatic drv_if(input int n);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          lat;
            logic [31:0] w;
            logic [31:0] r;
            bit          done;
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            w = $urandom_range(128, 255);
            r = $urandom();
            if_addr = (r & 32'hFFC00003) | (w << 2);
            push_if(w, rom(w));
            if_req = 1'b1;
            lat = 0;
            done = 1'b0;
            while (!done && lat < 20) begin
                @(negedge clk);
                lat++;
                done = !if_stall;
                step();
            end
            chk("if_done", {31'b0, done}, 32'h1);
            chk("if_latency_le4", (lat <= 4) ? 32'd1 : 32'd0, 32'd1);
            if_req = 1'b0;
        end
    endtask

    task automatic drv_mem(input int n);
        for (int i = 0; i < n; i++) begin
            int          gap;
            int          lat;
            int          w;
            logic [31:0] r;
            logic [31:0] wd;
            logic [3:0]  be;
            bit          done;
            gap = $urandom_range(1, 3);
            repeat (gap) step();
            w  = 256 + int'($urandom_range(0, 15));
            r  = $urandom();
            wd = $urandom();
            be = 4'($urandom_range(0, 15));
            mem_addr  = (r & 32'hFFC00003) | (32'(w) << 2);
            mem_we    = $urandom_range(0, 1) == 1;
            mem_wdata = wd;
            mem_be_n  = be;
            if (mem_we) push_mem_write(w, wd, be);
            else        push_mem_read(w, be);
            mem_req = 1'b1;
            lat = 0;
            done = 1'b0;
            while (!done && lat < 20) begin
                @(negedge clk);
                lat++;
                done = !mem_stall;
                step();
            end
            chk("mem_done", {31'b0, done}, 32'h1);
            chk("mem_latency_le3", (lat <= 3) ? 32'd1 : 32'd0, 32'd1);
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0;
        mem_wdata = 32'h0; mem_be_n = 4'hF;
        step();
        // Requests during reset must be ignored.
        if_req = 1'b1; if_addr = 32'h80000010;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80000100; mem_be_n = 4'h0;
        @(negedge clk);
        chk("rst_if_stall",  32'(if_stall), 32'h0);
        chk("rst_mem_stall", 32'(mem_stall), 32'h0);
        chk("rst_if_rdata",  if_rdata, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk_bus_idle("rst");
        step();
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_be_n = 4'hF;
        rst = 1'b0;
        step();

        directed_fetch();

        // Single MEM write.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80000100;
        mem_wdata = 32'hDEADBEEF; mem_be_n = 4'h0;
        push_mem_write(32'h40, 32'hDEADBEEF, 4'h0);
        @(negedge clk);
        chk("wr_c1_we_n",     32'(sram_we_n), 32'h1);
        chk("wr_c1_oe_n",     32'(sram_oe_n), 32'h1);
        chk("wr_c1_wdata_oe", 32'(sram_wdata_oe), 32'h1);
        chk("wr_c1_stall",    32'(mem_stall), 32'h1);
        chk("wr_c1_addr",     32'(sram_addr), 32'h00040);
        step();
        @(negedge clk);
        chk("wr_c2_we_n",     32'(sram_we_n), 32'h0);
        chk("wr_c2_wdata_oe", 32'(sram_wdata_oe), 32'h1);
        chk("wr_c2_stall",    32'(mem_stall), 32'h0);
        step();
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("wr_after_we_n", 32'(sram_we_n), 32'h1);
        chk("wr_after_wdata_oe", 32'(sram_wdata_oe), 32'h0);
        step();

        // Conflict: MEM read wins, IF follows immediately.
        if_req = 1'b1; if_addr = 32'h80000010;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80000100; mem_be_n = 4'h0;
        push_mem_read(32'h40, 4'h0);
        push_if(4, 32'h24020001);
        @(negedge clk);
        chk("cf_c1_addr",      32'(sram_addr), 32'h00040);
        chk("cf_c1_mem_stall", 32'(mem_stall), 32'h1);
        chk("cf_c1_if_stall",  32'(if_stall), 32'h1);
        step();
        @(negedge clk);
        chk("cf_c2_mem_stall", 32'(mem_stall), 32'h0);
        chk("cf_c2_if_stall",  32'(if_stall), 32'h1);
        chk("cf_c2_mem_rdata", mem_rdata, 32'hDEADBEEF);
        chk("cf_c2_if_rdata",  if_rdata, 32'h0);
        step();
        mem_req = 1'b0;
        @(negedge clk);
        chk("cf_c3_if_stall", 32'(if_stall), 32'h1);
        chk("cf_c3_addr",     32'(sram_addr), 32'h00004);
        chk("cf_c3_ce_n",     32'(sram_ce_n), 32'h0);
        step();
        @(negedge clk);
        chk("cf_c4_if_stall", 32'(if_stall), 32'h0);
        step();
        if_req = 1'b0;
        step();

        // Streaming fetch: three back-to-back accesses with no idle gap.
        for (int k = 0; k < 3; k++) begin
            if_addr = 32'h80000020 + 32'(4 * k);
            if_req  = 1'b1;
            push_if(8 + k, rom(8 + k));
            @(negedge clk);
            chk("st_grant_ce_n",  32'(sram_ce_n), 32'h0);
            chk("st_grant_addr",  32'(sram_addr), 32'(8 + k));
            chk("st_grant_stall", 32'(if_stall), 32'h1);
            step();
            @(negedge clk);
            chk("st_busy_ce_n",  32'(sram_ce_n), 32'h0);
            chk("st_busy_addr",  32'(sram_addr), 32'(8 + k));
            chk("st_busy_stall", 32'(if_stall), 32'h0);
            step();
        end
        if_req = 1'b0;
        step();

        // Reset in the BUSY cycle of a write aborts it.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80000104;
        mem_wdata = 32'h11223344; mem_be_n = 4'h0;
        @(negedge clk);
        chk("rb_c1_stall", 32'(mem_stall), 32'h1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rb_rst_we_n",      32'(sram_we_n), 32'h1);
        chk("rb_rst_ce_n",      32'(sram_ce_n), 32'h1);
        chk("rb_rst_mem_stall", 32'(mem_stall), 32'h0);
        chk("rb_rst_if_stall",  32'(if_stall), 32'h0);
        step();
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        chk("rb_idle_ce_n",  32'(sram_ce_n), 32'h1);
        chk("rb_idle_we_n",  32'(sram_we_n), 32'h1);
        chk("rb_idle_stall", 32'(mem_stall), 32'h0);
        chk("rb_not_written", sram_mem[9'h041], rom(32'h41));
        step();
        directed_fetch();

        // Randomized concurrent traffic.
        fork
            drv_if(40);
            drv_mem(40);
        join
        repeat (3) step();
        chk("if_queue_drained",  32'(exp_if.size()), 32'h0);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
